// File: rtl/fp_operand_queue.sv
// Operand queue in front of add_sub_main: buffers {a, b, op} with per-operand
// IEEE-754 class bits and a wrapping sequence tag, strict FIFO order.
module fp_operand_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         a,
    output logic [WIDTH-1:0]         b,
    output logic                     operation_select,
    output logic [1:0]               class_a,
    output logic [1:0]               class_b,
    output logic [7:0]               tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             op;
        logic [1:0]       ca;
        logic [1:0]       cb;
        logic [7:0]       tag;
    } entry_t;

    // Sign is not part of the magnitude passed in, so +/- forms classify alike.
    function automatic logic [1:0] f_class(input logic [WIDTH-2:0] mag);
        logic [7:0]       exp_f;
        logic [WIDTH-10:0] mant_f;
        exp_f  = mag[WIDTH-2 -: 8];
        mant_f = mag[WIDTH-10:0];
        if (exp_f == 8'hFF && mant_f != '0)
            f_class = 2'b11;
        else if (exp_f == 8'hFF)
            f_class = 2'b10;
        else if (exp_f == 8'h00 && mant_f == '0)
            f_class = 2'b01;
        else
            f_class = 2'b00;
    endfunction

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_tag_cnt;

    logic            w_push;
    logic            w_pop;
    entry_t          w_entry;
    entry_t          w_head;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_comb begin
        w_entry     = '0;
        w_entry.a   = in_a;
        w_entry.b   = in_b;
        w_entry.op  = in_op;
        w_entry.ca  = f_class(in_a[WIDTH-2:0]);
        w_entry.cb  = f_class(in_b[WIDTH-2:0]);
        w_entry.tag = r_tag_cnt;
    end

    // Storage is not reset; the empty-gated head mux hides stale contents.
    always_ff @(posedge clk) begin
        if (w_push && !flush)
            r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_tag_cnt <= '0;
        end else if (flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + AW'(1);
                r_tag_cnt <= r_tag_cnt + 8'd1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    always_comb begin
        w_head = '0;
        if (out_valid)
            w_head = r_mem[r_rd_ptr];
    end

    assign a                = w_head.a;
    assign b                = w_head.b;
    assign operation_select = w_head.op;
    assign class_a          = w_head.ca;
    assign class_b          = w_head.cb;
    assign tag              = w_head.tag;

endmodule
